// File: rtl/apb_xfer_controller.sv
// APB transfer sequencer for the AHB-to-APB bridge.
// Accepts one request at a time, decodes it to one of three peripheral
// selects, runs the APB SETUP/ENABLE phases and returns a registered response.
// Optional build macro: APB_WAIT_EN (honour pready, with a bounded wait abort).
module apb_xfer_controller #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [2:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ENABLE = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  logic [1:0] r_state;
  logic       r_err_defer;
  logic [2:0] w_sel;
  logic       w_hit;
  logic       w_accept;
  logic       w_complete;
  logic       w_abort;

  // Address decode: three 64 MiB windows starting at 0x8000_0000
  always_comb begin
    w_sel = '0;
    case (req_addr[31:26])
      6'b100000: w_sel = 3'b001;
      6'b100001: w_sel = 3'b010;
      6'b100010: w_sel = 3'b100;
      default:   w_sel = '0;
    endcase
  end

  assign w_hit = |w_sel;

`ifdef APB_WAIT_EN
  logic [3:0] r_wait_cnt;

  assign w_complete = (r_state == S_ENABLE) && pready;
  assign w_abort    = (r_state == S_ENABLE) && !pready && (r_wait_cnt == 4'(WAIT_LIMIT));

  // Count stalled ENABLE cycles; restart for every new transfer
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ENABLE) && !pready && !w_abort) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
`else
  logic w_unused_pready;

  assign w_unused_pready = pready;
  assign w_complete      = (r_state == S_ENABLE);
  assign w_abort         = 1'b0;
`endif

  assign req_ready = (r_state == S_IDLE) || w_complete;
  assign w_accept  = req_valid && req_ready;

  // Transfer sequencing, APB drive and response generation
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state     <= S_IDLE;
      r_err_defer <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_state <= S_SETUP;
              psel    <= w_sel;
              paddr   <= req_addr;
              pwrite  <= req_write;
              pwdata  <= req_wdata;
              penable <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ENABLE;
        end
        S_ENABLE: begin
          if (w_abort) begin
            r_state    <= S_ERR;
            psel       <= '0;
            penable    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (w_complete) begin
            resp_valid <= 1'b1;
            resp_rdata <= pwrite ? '0 : prdata;
            penable    <= 1'b0;
            if (w_accept && w_hit) begin
              r_state <= S_SETUP;
              psel    <= w_sel;
              paddr   <= req_addr;
              pwrite  <= req_write;
              pwdata  <= req_wdata;
            end else if (w_accept) begin
              // The ERR cycle already carries this transfer's completion
              // pulse, so the miss's error pulse follows one cycle later.
              r_state     <= S_ERR;
              r_err_defer <= 1'b1;
              psel        <= '0;
            end else begin
              r_state <= S_IDLE;
              psel    <= '0;
            end
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          if (r_err_defer) begin
            r_err_defer <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_xfer_controller.sv
// Directed bench for apb_xfer_controller; the pready-wait section runs only
// when APB_WAIT_EN is defined (DUT built with WAIT_LIMIT=3).
module tb_apb_xfer_controller;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int total = 0;
  int bad   = 0;

  apb_xfer_controller #(.WAIT_LIMIT(3)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1 time unit
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // {psel, penable, resp_valid, resp_err}
  function automatic logic [31:0] st();
    return {26'd0, psel, penable, resp_valid, resp_err};
  endfunction

  initial begin
    hreset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b1;
    tick();
    tick();
    chk("rst_state", st(), 32'h00);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    hreset = 1'b0;
    tick();

    // single write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'hDEAD_BEEF;
    #1 chk("wr_ready_idle", {31'd0, req_ready}, 32'd1);
    tick(); // T+1 SETUP
    req_valid = 1'b0;
    chk("wr_setup", st(), {26'd0, 3'b001, 3'b000});
    chk("wr_setup_ready", {31'd0, req_ready}, 32'd0);
    chk("wr_paddr", paddr, 32'h8000_0010);
    chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_pwrite", {31'd0, pwrite}, 32'd1);
    tick(); // T+2 ENABLE
    chk("wr_enable", st(), {26'd0, 3'b001, 3'b100});
    chk("wr_paddr_hold", paddr, 32'h8000_0010);
    tick(); // T+3 response
    chk("wr_resp", st(), {26'd0, 3'b000, 3'b010});
    chk("wr_resp_rdata", resp_rdata, 32'h0);
    tick();
    chk("wr_resp_gone", st(), 32'h00);

    // single read
    prdata = 32'h0000_0025;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8400_0004;
    tick();
    req_valid = 1'b0;
    chk("rd_setup", st(), {26'd0, 3'b010, 3'b000});
    chk("rd_pwrite", {31'd0, pwrite}, 32'd0);
    tick();
    chk("rd_enable", st(), {26'd0, 3'b010, 3'b100});
    tick();
    chk("rd_resp", st(), {26'd0, 3'b000, 3'b010});
    chk("rd_rdata", resp_rdata, 32'h0000_0025);
    tick();

    // back-to-back writes, req_valid held
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8800_0000; req_wdata = 32'h1111_1111;
    tick(); // SETUP #1
    chk("b2b_setup1", st(), {26'd0, 3'b100, 3'b000});
    req_addr = 32'h8000_0000; req_wdata = 32'h2222_2222;
    tick(); // ENABLE #1, accepting #2
    chk("b2b_enable1", st(), {26'd0, 3'b100, 3'b100});
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick(); // SETUP #2 + resp #1
    req_valid = 1'b0;
    chk("b2b_setup2", st(), {26'd0, 3'b001, 3'b010});
    chk("b2b_paddr2", paddr, 32'h8000_0000);
    chk("b2b_pwdata2", pwdata, 32'h2222_2222);
    tick();
    chk("b2b_enable2", st(), {26'd0, 3'b001, 3'b100});
    tick();
    chk("b2b_resp2", st(), {26'd0, 3'b000, 3'b010});
    tick();

    // decode miss
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9000_0000;
    tick();
    req_valid = 1'b0;
    chk("miss_err", st(), {26'd0, 3'b000, 3'b011});
    chk("miss_rdata", resp_rdata, 32'h0);
    chk("miss_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("miss_idle", st(), 32'h00);

    // completion followed directly by a miss: completion pulse, then error pulse
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8400_0000;
    tick();
    req_addr = 32'hA000_0000;
    tick();
    tick();
    req_valid = 1'b0;
    chk("hitmiss_resp1", st(), {26'd0, 3'b000, 3'b010});
    chk("hitmiss_rdata", resp_rdata, 32'h0000_0025);
    tick();
    chk("hitmiss_resp2", st(), {26'd0, 3'b000, 3'b011});
    tick();
    chk("hitmiss_idle", st(), 32'h00);

    // reset during ENABLE of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstmid_enable", st(), {26'd0, 3'b001, 3'b100});
    hreset = 1'b1;
    #1;
    chk("rstmid_state", st(), 32'h00);
    chk("rstmid_paddr", paddr, 32'h0);
    tick();
    hreset = 1'b0;
    tick();
    chk("rstmid_noresp", st(), 32'h00);
    prdata = 32'h0000_1234;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8800_0008;
    tick();
    req_valid = 1'b0;
    chk("post_rst_setup", st(), {26'd0, 3'b100, 3'b000});
    tick();
    chk("post_rst_enable", st(), {26'd0, 3'b100, 3'b100});
    tick();
    chk("post_rst_resp", st(), {26'd0, 3'b000, 3'b010});
    chk("post_rst_rdata", resp_rdata, 32'h0000_1234);
    tick();

`ifdef APB_WAIT_EN
    // pready low for two ENABLE cycles, then high
    pready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wait_en1", st(), {26'd0, 3'b001, 3'b100});
    chk("wait_ready1", {31'd0, req_ready}, 32'd0);
    tick();
    chk("wait_en2", st(), {26'd0, 3'b001, 3'b100});
    tick();
    chk("wait_en3", st(), {26'd0, 3'b001, 3'b100});
    pready = 1'b1;
    #1 chk("wait_ready3", {31'd0, req_ready}, 32'd1);
    tick();
    chk("wait_resp", st(), {26'd0, 3'b000, 3'b010});
    tick();

    // pready held low: abort after WAIT_LIMIT stalled cycles
    pready = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("abort_last_enable", st(), {26'd0, 3'b001, 3'b100});
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("abort_err", st(), {26'd0, 3'b000, 3'b011});
    chk("abort_rdata", resp_rdata, 32'h0);
    tick();
    chk("abort_idle", st(), 32'h00);
    pready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
